// File: rtl/audio_tone_gen.sv
// Audio sample source for the HDMI encoder: fractional-rate sample clock plus a DDS tone with an
// attack/sustain/release envelope. Define AUDIO_TONE_NOISE_EN to make wave_sel=2'b11 select noise.
module audio_tone_gen #(
  parameter int unsigned CLK_HZ       = 25175000,
  parameter int unsigned SAMPLE_RATE  = 48000,
  parameter int unsigned PHASE_W      = 24,
  parameter int unsigned ATTACK_STEP  = 8,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic                clk_pixel,
  input  logic                resetn,
  input  logic                trigger,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic [1:0]          wave_sel,
  input  logic [15:0]         duration,
  output logic                clk_audio,
  output logic [1:0][15:0]    audio_sample_word,
  output logic                busy,
  output logic [7:0]          level
);

  localparam logic [31:0] AccInc      = 32'(2 * SAMPLE_RATE);
  localparam logic [31:0] AccMod      = 32'(CLK_HZ);
  localparam logic [8:0]  AttackStep  = 9'(ATTACK_STEP);
  localparam logic [8:0]  ReleaseStep = 9'(RELEASE_STEP);

  typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} state_e;

  logic [31:0]         acc_q, acc_d, acc_sum;
  logic                clk_audio_q, clk_audio_d;
  logic                toggle, smp, smp_q;
  state_e              state_q, state_d;
  logic [7:0]          level_q, level_d;
  logic [15:0]         dur_q, dur_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                busy_q;
  logic [1:0][15:0]    audio_q, audio_d;
  logic [8:0]          lvl_up;
  logic [15:0]         p, w, out_l, out_r;
  logic [14:0]         tri_t;
  logic signed [24:0]  w_ext, lvl_ext, prod;

`ifdef AUDIO_TONE_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form of x^16 + x^15 + x^13 + x^4 + 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (smp) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hd008 : 16'h0000);
    end
  end
`endif

  // Rate accumulator: toggles clk_audio so its long-run frequency is exactly SAMPLE_RATE.
  always_comb begin
    acc_sum     = acc_q + AccInc;
    toggle      = (acc_sum >= AccMod);
    acc_d       = toggle ? (acc_sum - AccMod) : acc_sum;
    clk_audio_d = clk_audio_q ^ toggle;
    smp         = toggle & clk_audio_q;
  end

  assign lvl_up = {1'b0, level_q} + AttackStep;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dur_d   = dur_q;
    phase_d = phase_q;
    if (smp) begin
      phase_d = phase_q + freq_word;
    end
    // A trigger overrides any envelope step in the same cycle; level is kept to avoid clicks.
    if (trigger) begin
      state_d = StAttack;
      dur_d   = duration;
      if (state_q == StIdle) begin
        phase_d = '0;
      end
    end else if (smp) begin
      unique case (state_q)
        StIdle: level_d = '0;
        StAttack: begin
          if (lvl_up >= 9'd255) begin
            level_d = 8'hff;
            state_d = StSustain;
          end else begin
            level_d = lvl_up[7:0];
          end
        end
        StSustain: begin
          if (dur_q == 16'd0) begin
            state_d = StRelease;
          end else begin
            dur_d = dur_q - 16'd1;
          end
        end
        StRelease: begin
          if ({1'b0, level_q} <= ReleaseStep) begin
            level_d = '0;
            state_d = StIdle;
          end else begin
            level_d = level_q - ReleaseStep[7:0];
          end
        end
      endcase
    end
  end

  assign p = phase_q[PHASE_W-1 -: 16];

  always_comb begin
    w     = '0;
    tri_t = p[15] ? ~p[14:0] : p[14:0];
    unique case (wave_sel)
      2'b00:   w = p[15] ? 16'h8001 : 16'h7fff;
      2'b01:   w = {~p[15], p[14:0]};
      2'b10:   w = {~tri_t[14], tri_t[13:0], 1'b0};
      default: begin
`ifdef AUDIO_TONE_NOISE_EN
        w = lfsr_q;
`else
        w = '0;
`endif
      end
    endcase
  end

  // Signed wave times unsigned level; the product always fits in 25 bits.
  always_comb begin
    w_ext   = {{9{w[15]}}, w};
    lvl_ext = {17'b0, level_q};
    prod    = w_ext * lvl_ext;
    out_l   = 16'(prod >>> 8);
    out_r   = (out_l == 16'h8000) ? 16'h7fff : -out_l;
    audio_d = audio_q;
    if (smp_q) begin
      audio_d[0] = out_l;
      audio_d[1] = out_r;
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      smp_q       <= 1'b0;
      state_q     <= StIdle;
      level_q     <= '0;
      dur_q       <= '0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      audio_q     <= '0;
`ifdef AUDIO_TONE_NOISE_EN
      lfsr_q      <= 16'hace1;
`endif
    end else begin
      acc_q       <= acc_d;
      clk_audio_q <= clk_audio_d;
      smp_q       <= smp;
      state_q     <= state_d;
      level_q     <= level_d;
      dur_q       <= dur_d;
      phase_q     <= phase_d;
      busy_q      <= (state_d != StIdle);
      audio_q     <= audio_d;
`ifdef AUDIO_TONE_NOISE_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign clk_audio         = clk_audio_q;
  assign audio_sample_word = audio_q;
  assign busy              = busy_q;
  assign level             = level_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: closed-form rate model plus an event-level envelope/DDS model,
// compared every cycle, with literal expectations at key points.
module tb_audio_tone_gen;

  localparam int unsigned TbClkHz = 2517500;
  localparam int unsigned TbRate  = 48000;
  localparam int unsigned TbPw    = 24;
  localparam int unsigned TbAs    = 8;
  localparam int unsigned TbRs    = 1;
  localparam int SIdle = 0, SAtk = 1, SSus = 2, SRel = 3;

  logic              clk_pixel, resetn, trigger;
  logic [TbPw-1:0]   freq_word;
  logic [1:0]        wave_sel;
  logic [15:0]       duration;
  logic              clk_audio, busy;
  logic [1:0][15:0]  asw;
  logic [7:0]        level;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  typedef struct {
    longint ncy;
    int     st;
    int     lvl;
    int     dur;
    int     ph;
    int     lfsr;
    bit     smp_prev;
    int     l;
    int     r;
  } model_t;

  model_t m;

  audio_tone_gen #(
    .CLK_HZ      (TbClkHz),
    .SAMPLE_RATE (TbRate),
    .PHASE_W     (TbPw),
    .ATTACK_STEP (TbAs),
    .RELEASE_STEP(TbRs)
  ) dut (
    .clk_pixel        (clk_pixel),
    .resetn           (resetn),
    .trigger          (trigger),
    .freq_word        (freq_word),
    .wave_sel         (wave_sel),
    .duration         (duration),
    .clk_audio        (clk_audio),
    .audio_sample_word(asw),
    .busy             (busy),
    .level            (level)
  );

  initial begin
    clk_pixel = 0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Number of clk_audio toggles after n pixel edges since reset.
  function automatic longint toggles(input longint n);
    return (n * 2 * TbRate) / TbClkHz;
  endfunction

  function automatic bit smp_at(input longint n);
    return (toggles(n + 1) > toggles(n)) && (toggles(n) % 2 == 1);
  endfunction

  function automatic int lfsr_step(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? 32'hd008 : 0);
  endfunction

  function automatic int wave(input int ph, input int sel, input int lfsr);
    int pp, t;
    pp = (ph >> (TbPw - 16)) & 32'hffff;
    case (sel)
      0: return (pp >= 32768) ? -32767 : 32767;
      1: return pp - 32768;
      2: begin
        t = (pp < 32768) ? pp : 65535 - pp;
        return 2 * t - 32768;
      end
      default: begin
`ifdef AUDIO_TONE_NOISE_EN
        return (lfsr >= 32768) ? lfsr - 65536 : lfsr;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t z;
    z.ncy = 0; z.st = SIdle; z.lvl = 0; z.dur = 0; z.ph = 0; z.lfsr = 32'hace1;
    z.smp_prev = 0; z.l = 0; z.r = 0;
    return z;
  endfunction

  function automatic model_t model_next(input model_t c, input logic trg, input int fw,
                                        input int sel, input int dur);
    model_t n;
    bit     smp_now;
    int     prd;
    n = c;
    smp_now = smp_at(c.ncy);
    if (c.smp_prev) begin
      prd = wave(c.ph, sel, c.lfsr) * c.lvl;
      n.l = prd >>> 8;
      n.r = (n.l == -32768) ? 32767 : -n.l;
    end
    if (smp_now) begin
`ifdef AUDIO_TONE_NOISE_EN
      n.lfsr = lfsr_step(c.lfsr);
`endif
      n.ph = (c.ph + fw) & 32'h00ff_ffff;
    end
    if (trg) begin
      if (c.st == SIdle) n.ph = 0;
      n.st  = SAtk;
      n.dur = dur;
    end else if (smp_now) begin
      case (c.st)
        SAtk: begin
          n.lvl = (c.lvl + TbAs > 255) ? 255 : c.lvl + TbAs;
          if (n.lvl == 255) n.st = SSus;
        end
        SSus: begin
          if (c.dur == 0) n.st = SRel;
          else n.dur = c.dur - 1;
        end
        SRel: begin
          n.lvl = (c.lvl < TbRs) ? 0 : c.lvl - TbRs;
          if (n.lvl == 0) n.st = SIdle;
        end
        default: n.lvl = 0;
      endcase
    end
    n.ncy      = c.ncy + 1;
    n.smp_prev = smp_now;
    return n;
  endfunction

  always @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) m <= model_reset();
    else m <= model_next(m, trigger, int'(freq_word), int'(wave_sel), int'(duration));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_pixel) begin
    if (chk_en) begin
      chk("clk_audio", int'(clk_audio), int'(toggles(m.ncy) % 2));
      chk("level", int'(level), m.lvl);
      chk("busy", int'(busy), (m.st != SIdle) ? 1 : 0);
      chk("left", int'($signed(asw[0])), m.l);
      chk("right", int'($signed(asw[1])), m.r);
    end
  end

  task automatic wait_smp(input int k);
    for (int i = 0; i < k; i++) begin
      int guard;
      guard = 0;
      do begin
        @(negedge clk_pixel);
        guard++;
      end while (!m.smp_prev && guard < 200);
      if (!m.smp_prev) begin
        checks++;
        errors++;
        $display("FAIL smp_timeout at %0t: got none expected strobe", $time);
        return;
      end
    end
  endtask

  task automatic pulse_trigger();
    @(negedge clk_pixel);
    trigger = 1;
    @(negedge clk_pixel);
    trigger = 0;
  endtask

  task automatic first_toggle_check(input string name);
    int first;
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      @(negedge clk_pixel);
      if (clk_audio) first = k;
    end
    chk(name, first, 27);
  endtask

  initial begin
    logic prev;
    int   last, rises, hl, guard;
    trigger = 0; freq_word = '0; wave_sel = 2'b00; duration = '0;
    resetn = 1;
    #2 resetn = 0;
    #1 chk_en = 1;
    chk("rst_clk_audio", int'(clk_audio), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_left", int'(asw[0]), 0);
    chk("rst_right", int'(asw[1]), 0);

    // Rate: 10070 edges is exactly 384 toggles at this clock ratio.
    @(negedge clk_pixel);
    resetn = 1;
    prev = 0; last = 0; rises = 0;
    for (int k = 1; k <= 10070; k++) begin
      @(negedge clk_pixel);
      if (clk_audio !== prev) begin
        hl = k - last;
        if (last == 0) chk("first_toggle", k, 27);
        else begin
          checks++;
          if (!(hl == 26 || hl == 27)) begin
            errors++;
            $display("FAIL half_period: got %0d expected 26 or 27", hl);
          end
        end
        if (clk_audio) rises++;
        prev = clk_audio;
        last = k;
      end
    end
    chk("rise_count", rises, 192);

    // Envelope on a square tone.
    freq_word = 24'h010000; wave_sel = 2'b00; duration = 16'd10;
    pulse_trigger();
    wait_smp(1);   chk("atk_first", int'(level), 8);
    chk("atk_busy", int'(busy), 1);
    wait_smp(31);  chk("atk_top", int'(level), 255);
    wait_smp(11);  chk("sus_end", int'(level), 255);
    wait_smp(1);   chk("rel_first", int'(level), 254);
    wait_smp(253); chk("rel_last", int'(level), 1);
    chk("rel_busy", int'(busy), 1);
    wait_smp(1);   chk("idle_level", int'(level), 0);
    chk("idle_busy", int'(busy), 0);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    chk("idle_left", int'(asw[0]), 0);
    chk("idle_right", int'(asw[1]), 0);

    // Sawtooth at phase 0 and full level, then a running ramp.
    freq_word = '0; wave_sel = 2'b01; duration = 16'd1000;
    pulse_trigger();
    wait_smp(32);
    @(negedge clk_pixel);
    chk("saw_left", int'($signed(asw[0])), -32640);
    chk("saw_right", int'($signed(asw[1])), 32640);
    freq_word = 24'h020000;
    wait_smp(140);

    // Retrigger during release at level 100.
    duration = 16'd0;
    pulse_trigger();
    guard = 0;
    do begin
      wait_smp(1);
      guard++;
    end while (level != 8'd100 && guard < 400);
    chk("reach_100", int'(level), 100);
    duration = 16'd1000;
    pulse_trigger();
    wait_smp(1); chk("retrig_1", int'(level), 108);
    wait_smp(1); chk("retrig_2", int'(level), 116);

    // Trigger landing on the strobe edge: no level step that sample.
    guard = 0;
    while (!smp_at(m.ncy) && guard < 100) begin
      @(negedge clk_pixel);
      guard++;
    end
    trigger = 1;
    @(negedge clk_pixel);
    trigger = 0;
    chk("coinc_hold", int'(level), 116);
    wait_smp(1); chk("coinc_next", int'(level), 124);

    // Asynchronous reset mid-sustain; a trigger during reset is ignored.
    guard = 0;
    do begin
      wait_smp(1);
      guard++;
    end while (level != 8'd255 && guard < 40);
    wait_smp(2);
    chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk_pixel);
    #3 resetn = 0;
    trigger = 1;
    #1;
    chk("arst_clk_audio", int'(clk_audio), 0);
    chk("arst_level", int'(level), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_left", int'(asw[0]), 0);
    chk("arst_right", int'(asw[1]), 0);
    @(negedge clk_pixel);
    trigger = 0;
    @(negedge clk_pixel);
    resetn = 1;
    first_toggle_check("arst_first_toggle");
    chk("arst_idle", int'(busy), 0);

    // Noise select.
    wave_sel = 2'b11; freq_word = 24'h123456; duration = 16'd20;
    pulse_trigger();
    wait_smp(40);
    @(negedge clk_pixel);
    chk("noise_level", int'(level), 255);
`ifndef AUDIO_TONE_NOISE_EN
    chk("noise_off_left", int'(asw[0]), 0);
    chk("noise_off_right", int'(asw[1]), 0);
`endif

    // Randomized stimulus, checked every cycle against the model.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk_pixel);
      trigger = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 399) == 0) freq_word = 24'($urandom);
      if ($urandom_range(0, 299) == 0) wave_sel = 2'($urandom_range(0, 3));
      duration = 16'($urandom_range(0, 40));
    end
    trigger = 0;
    @(negedge clk_pixel);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
